spi_cfg_master: RTL

- Multi-requester SPI write sequencer that configures the on-chip SPI register peripheral: output enables, PWM enables and PWM duty cycle.
- Arbitrates round-robin between N_REQ register-write requesters.
- Serialises the granted request into one 16-bit write frame on cs/sclk/COPI.
- Generates sclk and cs slowly enough that the peripheral's 2-flop synchronisers and edge detectors in the clk domain capture every edge.

---
 rtl/spi_cfg_pkg.sv | 31 +++
 rtl/spi_cfg_master_rr_arbiter.sv | 47 ++++
 rtl/spi_cfg_master.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_cfg_pkg.sv
// spi_cfg_pkg: shared types and constants for the SPI config write master.
// Holds the FSM state enum, frame geometry and peripheral register map.
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    HIGH,
    LOW,
    HOLD,
    GAP
  } state_t;

  localparam int FRAME_BITS  = 16;
  localparam int SCLK_PULSES = 17;
  localparam logic WRITE_BIT = 1'b1;

  localparam logic [6:0] ADDR_EN_OUT_7_0  = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_15_8 = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_7_0  = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_15_8 = 7'h03;
  localparam logic [6:0] ADDR_PWM_DUTY    = 7'h04;

  function automatic logic [FRAME_BITS-1:0] make_frame(
    input logic [6:0] addr,
    input logic [7:0] data
  );
    return {WRITE_BIT, addr, data};
  endfunction

endpackage

// File: rtl/spi_cfg_master_rr_arbiter.sv
// rr_arbiter: round-robin arbiter, pointer holds the last granted index.
// Ports: clk, rst, req (one bit per requester), advance (commit grant),
//        grant (one-hot, combinational from req and pointer).
module rr_arbiter #(
  parameter int N_REQ = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             advance,
  output logic [N_REQ-1:0] grant
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] next_idx;
  logic          found;

  // Search starts one past the last winner so a requester that stays
  // valid only wins again when nobody else is asking.
  always_comb begin
    int idx;
    idx      = 0;
    grant    = '0;
    next_idx = ptr;
    found    = 1'b0;
    for (int off = 1; off <= N_REQ; off++) begin
      idx = (int'(ptr) + off) % N_REQ;
      if (!found && req[idx]) begin
        found       = 1'b1;
        grant[idx]  = 1'b1;
        next_idx    = PW'(idx);
      end
    end
  end

  // Reset points at the last requester so requester 0 is searched first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= PW'(N_REQ - 1);
    end else if (advance && found) begin
      ptr <= next_idx;
    end
  end

endmodule

// File: rtl/spi_cfg_master.sv
// spi_cfg_master: arbitrates register-write requesters and sends each
// granted write as one 16-bit frame plus a commit pulse on cs/sclk/COPI.
// Ports: clk, rst (async, active high); req_valid/req_addr/req_data
//        packed per requester; done (per-requester pulse), busy;
//        sclk (mode 0), COPI (MSB first), cs (active low).
module spi_cfg_master
  import spi_cfg_pkg::*;
#(
  parameter int N_REQ    = 2,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 4,
  parameter int CS_HOLD  = 4,
  parameter int CS_GAP   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_data,
  output logic [N_REQ-1:0]   done,
  output logic               busy,
  output logic               sclk,
  output logic               COPI,
  output logic               cs
);

  // Slow edges keep the peripheral's 2-flop synchronisers honest.
  localparam int DIV_N   = (CLK_DIV < 4) ? 4 : CLK_DIV;
  localparam int SETUP_N = (CS_SETUP < 3) ? 3 : CS_SETUP;
  localparam int HOLD_N  = (CS_HOLD < 1) ? 1 : CS_HOLD;
  localparam int GAP_N   = (CS_GAP < 3) ? 3 : CS_GAP;

  localparam int CW = 16;
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_N - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_N - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_N - 1);
  localparam logic [CW-1:0] GAP_LAST   = CW'(GAP_N - 1);
  localparam logic [4:0]    LAST_PULSE = 5'(SCLK_PULSES - 1);

  state_t                state;
  logic [CW-1:0]         cnt;
  logic [4:0]            pulse;
  logic [FRAME_BITS-2:0] shreg;
  logic [N_REQ-1:0]      gnt_q;

  logic [N_REQ-1:0]      grant;
  logic                  advance;
  logic [6:0]            sel_addr;
  logic [7:0]            sel_data;
  logic [FRAME_BITS-1:0] frame;

  assign advance = (state == IDLE) && (|req_valid);

  rr_arbiter #(
    .N_REQ (N_REQ)
  ) u_arb (
    .clk     (clk),
    .rst     (rst),
    .req     (req_valid),
    .advance (advance),
    .grant   (grant)
  );

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant[i]) begin
        sel_addr = req_addr[7*i +: 7];
        sel_data = req_data[8*i +: 8];
      end
    end
  end

  assign frame = make_frame(sel_addr, sel_data);

  // Bit 15 goes straight onto COPI at grant; the remaining 15 bits shift
  // out on each falling edge, and zeros follow for the commit pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      pulse <= '0;
      shreg <= '0;
      gnt_q <= '0;
      cs    <= 1'b1;
      sclk  <= 1'b0;
      COPI  <= 1'b0;
      done  <= '0;
      busy  <= 1'b0;
    end else begin
      done <= '0;
      unique case (state)
        IDLE: begin
          if (|req_valid) begin
            state <= SETUP;
            cnt   <= '0;
            pulse <= '0;
            gnt_q <= grant;
            shreg <= frame[FRAME_BITS-2:0];
            COPI  <= frame[FRAME_BITS-1];
            cs    <= 1'b0;
            busy  <= 1'b1;
          end
        end
        SETUP: begin
          if (cnt == SETUP_LAST) begin
            state <= HIGH;
            cnt   <= '0;
            sclk  <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HIGH: begin
          if (cnt == DIV_LAST) begin
            state <= LOW;
            cnt   <= '0;
            sclk  <= 1'b0;
            COPI  <= shreg[FRAME_BITS-2];
            shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        LOW: begin
          if (cnt == DIV_LAST) begin
            cnt <= '0;
            if (pulse == LAST_PULSE) begin
              state <= HOLD;
            end else begin
              state <= HIGH;
              sclk  <= 1'b1;
              pulse <= pulse + 5'd1;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state <= GAP;
            cnt   <= '0;
            cs    <= 1'b1;
            done  <= gnt_q;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
